// File: rtl/dct_blk_sched.sv
// Block scheduler for the shared dct_top: arbitrates forward-DCT / IDCT requesters,
// streams one 8x8 block per grant and counts its 64 results before signalling done.
module dct_blk_sched #(
  parameter int D_WIDTH = 13,
  parameter int TIMEOUT = 2047,
  parameter int MIN_GAP = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         req,
  output logic [1:0]         gnt,
  output logic [1:0]         done,
  output logic               err,
  output logic               src_ren,
  output logic [5:0]         src_raddr,
  input  logic [D_WIDTH-1:0] src_rdata0,
  input  logic [D_WIDTH-1:0] src_rdata1,
  output logic               dct_flag,
  output logic               rm_data_en,
  output logic [6:0]         rm_data_idx,
  output logic [D_WIDTH-1:0] rm_data,
  input  logic               dct_out_en,
  input  logic [5:0]         dct_out_idx
);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, DONE, GAP} state_t;

  state_t           state;
  logic             rr_last;
  logic [5:0]       res_cnt;
  logic             res_wrap;
  logic [WD_W-1:0]  wd_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             win0, res_last, wd_last, gap_last, unused_idx;

  // requester 0 wins when alone, or on a tie when requester 1 was served last
  assign win0       = req[0] & (~req[1] | rr_last);
  assign res_last   = res_wrap | (dct_out_en & (res_cnt == 6'd63));
  assign wd_last    = (32'(wd_cnt) + 32'd1 >= 32'(TIMEOUT));
  assign gap_last   = (32'(gap_cnt) + 32'd1 >= 32'(MIN_GAP));
  assign unused_idx = ^dct_out_idx;

  // The sample buffers already register their read, so their output lines up
  // with the delayed strobe; only the requester select is needed here.
  assign rm_data = rm_data_en ? (gnt[0] ? src_rdata0 : src_rdata1) : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_last     <= 1'b1;
      gnt         <= '0;
      done        <= '0;
      err         <= 1'b0;
      dct_flag    <= 1'b0;
      src_ren     <= 1'b0;
      src_raddr   <= '0;
      rm_data_en  <= 1'b0;
      rm_data_idx <= '0;
      res_cnt     <= '0;
      res_wrap    <= 1'b0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      done        <= '0;
      err         <= 1'b0;
      rm_data_en  <= src_ren;
      rm_data_idx <= src_ren ? {1'b0, src_raddr} : '0;
      // results may overtake the load phase; the wrap flag saturates the count at 64
      if (dct_out_en && !res_wrap && (state == LOAD || state == DRAIN))
        {res_wrap, res_cnt} <= {res_wrap, res_cnt} + 7'd1;
      case (state)
        IDLE: if (req != 2'b00) begin
          gnt       <= win0 ? 2'b01 : 2'b10;
          dct_flag  <= win0;
          src_ren   <= 1'b1;
          src_raddr <= '0;
          res_cnt   <= '0;
          res_wrap  <= 1'b0;
          state     <= LOAD;
        end
        LOAD: if (src_raddr == 6'd63) begin
          src_ren   <= 1'b0;
          src_raddr <= '0;
          wd_cnt    <= '0;
          state     <= DRAIN;
        end else begin
          src_raddr <= src_raddr + 6'd1;
        end
        DRAIN: if (res_last) begin
          done  <= gnt;
          state <= DONE;
        end else if (wd_last) begin
          done  <= gnt;
          err   <= 1'b1;
          state <= DONE;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
        DONE: begin
          gnt     <= '0;
          rr_last <= gnt[1];
          gap_cnt <= '0;
          state   <= (MIN_GAP == 0) ? IDLE : GAP;
        end
        GAP: if (gap_last) state <= IDLE;
             else          gap_cnt <= gap_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dct_blk_sched.sv
// Randomized bench for dct_blk_sched: sync-read buffers, fixed-latency dct_top stand-in,
// and a block-level reference for arbitration, sample stream, result count and timing.
module tb_dct_blk_sched;
  localparam int DW = 13, TO = 100, MG = 2, LAT = 20;

  logic          clock = 1'b0, reset_n = 1'b0;
  logic [1:0]    req = '0;
  logic [1:0]    gnt, done;
  logic          err, src_ren, dct_flag, rm_data_en, dct_out_en;
  logic [5:0]    src_raddr;
  logic [5:0]    dct_out_idx = '0;
  logic [DW-1:0] src_rdata0 = '0, src_rdata1 = '0, rm_data;
  logic [6:0]    rm_data_idx;

  logic [DW-1:0]  mem0 [64];
  logic [DW-1:0]  mem1 [64];
  logic [LAT-1:0] pipe;
  bit             res_on = 1'b1, xtra = 1'b0;
  int             cyc = 0, errors = 0, checks = 0;
  int             flag_bad = 0, res_seen = 0, t64 = -1, last_en_cyc = 0, prev_done = -1;
  bit             last_win = 1'b1;
  logic [6:0]     sq_idx [$];
  logic [DW-1:0]  sq_dat [$];

  dct_blk_sched #(.D_WIDTH(DW), .TIMEOUT(TO), .MIN_GAP(MG)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .gnt(gnt), .done(done), .err(err),
    .src_ren(src_ren), .src_raddr(src_raddr), .src_rdata0(src_rdata0), .src_rdata1(src_rdata1),
    .dct_flag(dct_flag), .rm_data_en(rm_data_en), .rm_data_idx(rm_data_idx), .rm_data(rm_data),
    .dct_out_en(dct_out_en), .dct_out_idx(dct_out_idx)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // requester buffers: data for an address appears the cycle after the read strobe
  always @(posedge clock) if (src_ren) begin
    src_rdata0 <= mem0[src_raddr];
    src_rdata1 <= mem1[src_raddr];
  end

  // dct_top stand-in: one result per sample, LAT cycles later; flushed by the shared reset
  always @(posedge clock or negedge reset_n)
    if (!reset_n) pipe <= '0;
    else          pipe <= {pipe[LAT-2:0], rm_data_en};
  always @(posedge clock) dct_out_idx <= 6'($urandom);
  assign dct_out_en = (res_on & pipe[LAT-1]) | xtra;

  always @(negedge clock) begin
    if (rm_data_en) begin
      sq_idx.push_back(rm_data_idx);
      sq_dat.push_back(rm_data);
      last_en_cyc = cyc;
    end
    if (gnt == 2'b00) res_seen = 0;
    else if (done == 2'b00) begin
      if (dct_flag !== gnt[0]) flag_bad++;
      if (dct_out_en) begin
        res_seen++;
        if (res_seen == 64) t64 = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input bit ramp);
    for (int i = 0; i < 64; i++) begin
      mem0[i] = ramp ? DW'(i) : DW'($urandom);
      mem1[i] = DW'($urandom);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({gnt, done, err, src_ren, src_raddr, dct_flag, rm_data_en, rm_data_idx}), 32'd0);
    chk({tag, "_data"}, 32'(rm_data), 32'd0);
  endtask

  // one whole block: expected winner from round-robin rules, then stream, results, done
  task automatic run_block(input logic [1:0] rq, input bit drop10, input bit exp_err, input bit b2b);
    bit         w;
    logic [1:0] eg;
    int         n, tg, td, bad;
    w  = (rq == 2'b11) ? !last_win : rq[1];
    eg = w ? 2'b10 : 2'b01;
    sq_idx.delete();
    sq_dat.delete();
    t64 = -1;
    flag_bad = 0;
    req = rq;
    n = 0;
    while (gnt == 2'b00 && n < 20) begin @(negedge clock); n++; end
    tg = cyc;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("dct_flag", 32'(dct_flag), 32'(!w));
    if (b2b) chk("gap", tg - prev_done, MG + 2);
    if (drop10) begin
      n = 0;
      while (!(src_ren && src_raddr == 6'd10) && n < 80) begin @(negedge clock); n++; end
      req = 2'b00;
    end
    n = 0;
    while (done == 2'b00 && n < 400) begin @(negedge clock); n++; end
    td = cyc;
    chk("done", 32'(done), 32'(eg));
    chk("err", 32'(err), 32'(exp_err));
    if (exp_err) chk("wd_time", td - last_en_cyc, TO);
    else         chk("done_time", td - t64, 1);
    chk("nsamp", sq_idx.size(), 64);
    bad = 0;
    for (int i = 0; i < sq_idx.size() && i < 64; i++)
      if (sq_idx[i] !== 7'(i) || sq_dat[i] !== (w ? mem1[i] : mem0[i])) bad++;
    chk("samples", bad, 0);
    chk("flag_stable", flag_bad, 0);
    last_win  = w;
    prev_done = td;
    @(negedge clock);
    chk("done_pulse", 32'({done, err}), 32'd0);
    chk("gnt_clear", 32'(gnt), 32'd0);
    fill(1'b0);
  endtask

  initial begin
    int n, cnt;
    fill(1'b1);
    @(negedge clock);
    chk_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    wait_cyc(2);
    chk("idle_gnt", 32'(gnt), 32'd0);

    // single requester, ramp data; then stray results while idle must not count
    run_block(2'b01, 1'b0, 1'b0, 1'b0);
    req = 2'b00;
    xtra = 1'b1;
    wait_cyc(3);
    xtra = 1'b0;
    wait_cyc(2);
    run_block(2'b01, 1'b0, 1'b0, 1'b0);
    req = 2'b00;

    // contention from a fresh reset: grants alternate starting with requester 0
    reset_n = 1'b0;
    wait_cyc(2);
    reset_n = 1'b1;
    last_win = 1'b1;
    wait_cyc(1);
    for (int k = 0; k < 4; k++) run_block(2'b11, 1'b0, 1'b0, k > 0);
    req = 2'b00;
    wait_cyc(5);

    // request withdrawn mid-load: block finishes, nothing re-granted
    run_block(2'b10, 1'b1, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (gnt != 2'b00) cnt++;
    end
    chk("no_regrant", cnt, 0);

    // random request mixes, back to back
    for (int k = 0; k < 8; k++) run_block(2'($urandom_range(1, 3)), 1'b0, 1'b0, k > 0);
    req = 2'b00;
    wait_cyc(5);

    // dct_top never answers: watchdog abort, then normal service resumes
    res_on = 1'b0;
    run_block(2'b01, 1'b0, 1'b1, 1'b0);
    res_on = 1'b1;
    req = 2'b00;
    wait_cyc(5);
    chk("post_abort_idle", 32'(gnt), 32'd0);
    run_block(2'b10, 1'b0, 1'b0, 1'b0);
    req = 2'b00;
    wait_cyc(3);

    // reset in the middle of a load clears everything at once; block restarts at 0
    req = 2'b01;
    n = 0;
    while (!(src_ren && src_raddr == 6'd30) && n < 100) begin @(negedge clock); n++; end
    chk("rst_point", 32'(src_raddr), 32'd30);
    reset_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    wait_cyc(2);
    reset_n = 1'b1;
    last_win = 1'b1;
    run_block(2'b01, 1'b0, 1'b0, 1'b0);
    req = 2'b00;
    wait_cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
